dfr_sequencer: RTL and testbench
================================

Name: dfr_sequencer

Overview:
Controller that runs the delayed-feedback reservoir over a batch of input samples. On start it clears all virtual nodes, then for each sample and each virtual node: fetches sample and mask words, forms the masked input, and pulses the reservoir update. After each sample it sweeps the node states into an output memory. It sits between the host register block, the sample/mask/output BRAMs and the reservoir datapath.

Parameters:
NUM_VIRTUAL_NODES, 100, virtual nodes in reservoir
DATA_WIDTH, 32, reservoir din width
NODE_DATA_WIDTH, 12, node state width
SAMPLE_WIDTH, 16, input sample width (unsigned)
MASK_WIDTH, 16, mask word width (unsigned)
MASK_SHIFT, 8, right shift applied to sample*mask product
ADDR_WIDTH, 16, sample and output memory address width
TIMEOUT, 255, max cycles waiting for res_valid

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse; ignored unless idle
num_samples  in  ADDR_WIDTH  samples in batch, latched on start
eta_cfg  in  4  feedback scale, latched on start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse on completion
error  out  1  sticky; set on timeout, cleared by next accepted start
smp_addr  out  ADDR_WIDTH  sample memory read address
smp_data  in  SAMPLE_WIDTH  sample data, 1-cycle read latency
mask_addr  out  $clog2(NUM_VIRTUAL_NODES)  mask memory read address
mask_data  in  MASK_WIDTH  mask data, 1-cycle read latency
res_en  out  1  reservoir update pulse
res_din  out  DATA_WIDTH  masked input to reservoir
res_eta  out  4  latched eta_cfg
res_valid  in  1  reservoir idle/valid
res_load_node  out  1  node load strobe
res_load_din  out  NODE_DATA_WIDTH  node load value (always 0)
res_node_sel  out  $clog2(NUM_VIRTUAL_NODES)  node select for load/readback
res_node_dout  in  NODE_DATA_WIDTH  selected node state (combinational)
out_we  out  1  output memory write enable
out_addr  out  ADDR_WIDTH  output memory address
out_data  out  NODE_DATA_WIDTH  output memory data

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, error 0.
- States: IDLE -> CLEAR -> FETCH -> LATCH -> STEP -> WAIT -> (FETCH | READOUT) -> (FETCH | DONE) -> IDLE.
- IDLE: start accepted -> latch num_samples, eta_cfg; clear error, sample_idx, node_idx, out_addr; busy=1. start with num_samples=0 -> straight to DONE (done pulse, no memory/reservoir activity).
- CLEAR: NUM_VIRTUAL_NODES cycles, res_load_node=1, res_node_sel=0..N-1, one per cycle.
- FETCH: drive smp_addr=sample_idx, mask_addr=node_idx (1 cycle). LATCH: capture smp_data, mask_data.
- STEP: res_en=1 for exactly one cycle; res_din = (sample*mask)>>MASK_SHIFT, zero-extended; if value > 0xFFFF, saturate to 0x0000FFFF. res_din held stable from STEP until leaving WAIT.
- WAIT: ignore res_valid in first cycle after STEP; thereafter res_valid=1 -> advance. Timeout counter > TIMEOUT -> set error, pulse done, go IDLE (batch aborted).
- Advance: node_idx<N-1 -> node_idx+1, FETCH; else node_idx=0, READOUT.
- READOUT: N cycles, res_node_sel=k, out_we=1, out_data=res_node_dout, out_addr increments each write (wraps at 2^ADDR_WIDTH, no flag). Then sample_idx+1; if == num_samples -> DONE else FETCH. Node state is NOT cleared between samples.
- DONE: done=1 one cycle, busy=0 next cycle.
- start while busy: ignored. Reset mid-batch: immediate return to IDLE, all strobes low, no further writes.
- res_load_node, res_en, out_we never asserted in the same cycle.

Test Plan:
- Reset mid-READOUT -> out_we drops same cycle, busy=0, error=0, subsequent start runs normally.
- N=4, num_samples=1, sample=0x0100, masks all 0x0100 -> 4 CLEAR loads, 4 res_en pulses each with res_din=0x00000100, then 4 writes at out_addr 0..3, done pulse, busy low.
- sample=0xFFFF, mask=0xFFFF -> res_din saturates to 0x0000FFFF; sample=0x0002, mask=0x0080 -> res_din=0x00000001.
- res_valid tied low after first res_en -> error=1 and done after TIMEOUT+ cycles, no out_we; next start clears error.
- num_samples=0 -> done pulse 1 cycle after start, no res_en/out_we/res_load_node.
- num_samples=3, N=4 -> 12 output writes at addresses 0..11, start pulses during busy ignored, res_eta equals eta_cfg latched at start despite later changes.

Source files
------------

// File: rtl/dfr_sequencer.sv
// dfr_sequencer: batch controller for the delayed-feedback reservoir.
// Clears all virtual nodes, then for every sample walks the virtual nodes:
// fetch sample/mask, form the scaled masked input, pulse the reservoir and
// wait for it to settle. After each sample the node states are swept into
// the output memory.
module dfr_sequencer #(
    parameter int NUM_VIRTUAL_NODES = 100,
    parameter int DATA_WIDTH        = 32,
    parameter int NODE_DATA_WIDTH   = 12,
    parameter int SAMPLE_WIDTH      = 16,
    parameter int MASK_WIDTH        = 16,
    parameter int MASK_SHIFT        = 8,
    parameter int ADDR_WIDTH        = 16,
    parameter int TIMEOUT           = 255
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [ADDR_WIDTH-1:0]                num_samples,
    input  logic [3:0]                           eta_cfg,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 error,
    output logic [ADDR_WIDTH-1:0]                smp_addr,
    input  logic [SAMPLE_WIDTH-1:0]              smp_data,
    output logic [$clog2(NUM_VIRTUAL_NODES)-1:0] mask_addr,
    input  logic [MASK_WIDTH-1:0]                mask_data,
    output logic                                 res_en,
    output logic [DATA_WIDTH-1:0]                res_din,
    output logic [3:0]                           res_eta,
    input  logic                                 res_valid,
    output logic                                 res_load_node,
    output logic [NODE_DATA_WIDTH-1:0]           res_load_din,
    output logic [$clog2(NUM_VIRTUAL_NODES)-1:0] res_node_sel,
    input  logic [NODE_DATA_WIDTH-1:0]           res_node_dout,
    output logic                                 out_we,
    output logic [ADDR_WIDTH-1:0]                out_addr,
    output logic [NODE_DATA_WIDTH-1:0]           out_data
);

    localparam int NW = $clog2(NUM_VIRTUAL_NODES);
    localparam int PW = SAMPLE_WIDTH + MASK_WIDTH;
    localparam int TW = $clog2(TIMEOUT + 2);
    localparam logic [NW-1:0] LAST_NODE = NW'(NUM_VIRTUAL_NODES - 1);
    localparam int SAT_MAX = 32'h0000_FFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_LATCH,
        S_STEP,
        S_WAIT,
        S_READOUT,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [NW-1:0]         node_idx;
    logic [ADDR_WIDTH-1:0] sample_idx;
    logic [ADDR_WIDTH-1:0] num_q;
    logic [3:0]            eta_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [TW-1:0]         tmo_cnt;
    logic [DATA_WIDTH-1:0] din_q;

    logic accept;
    logic wait_go;
    logic wait_tmo;
    logic last_node;
    logic last_sample;

    // Scale sample by mask, drop MASK_SHIFT fraction bits, clamp to 16 bits.
    function automatic logic [DATA_WIDTH-1:0] scale_sat(
        input logic [SAMPLE_WIDTH-1:0] smp,
        input logic [MASK_WIDTH-1:0]   msk
    );
        logic [PW-1:0] prod;
        logic [PW-1:0] shifted;
        prod    = PW'(smp) * PW'(msk);
        shifted = prod >> MASK_SHIFT;
        if (shifted > PW'(SAT_MAX)) begin
            return DATA_WIDTH'(SAT_MAX);
        end
        return DATA_WIDTH'(shifted);
    endfunction

    assign accept      = (state == S_IDLE) && start;
    // The first WAIT cycle (tmo_cnt == 0) ignores res_valid: the reservoir
    // may not have dropped it yet in response to res_en.
    assign wait_go     = (state == S_WAIT) && (tmo_cnt != '0) && res_valid;
    assign wait_tmo    = (state == S_WAIT) && !wait_go && (tmo_cnt > TW'(TIMEOUT));
    assign last_node   = (node_idx == LAST_NODE);
    assign last_sample = ((sample_idx + ADDR_WIDTH'(1)) == num_q);

    assign smp_addr     = sample_idx;
    assign mask_addr    = node_idx;
    assign res_din      = din_q;
    assign res_eta      = eta_q;
    assign res_load_din = '0;
    assign out_addr     = addr_q;
    assign error        = err_q;

    // State register; reset aborts any batch immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-state strobes (strobes are mutually exclusive by state).
    always_comb begin
        state_next    = state;
        busy          = 1'b0;
        done          = 1'b0;
        res_en        = 1'b0;
        res_load_node = 1'b0;
        out_we        = 1'b0;
        res_node_sel  = '0;
        out_data      = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (num_samples == '0) ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                busy          = 1'b1;
                res_load_node = 1'b1;
                res_node_sel  = node_idx;
                if (last_node) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                busy       = 1'b1;
                state_next = S_LATCH;
            end
            S_LATCH: begin
                busy       = 1'b1;
                state_next = S_STEP;
            end
            S_STEP: begin
                busy       = 1'b1;
                res_en     = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (wait_go) begin
                    state_next = last_node ? S_READOUT : S_FETCH;
                end else if (wait_tmo) begin
                    state_next = S_DONE;
                end
            end
            S_READOUT: begin
                busy         = 1'b1;
                out_we       = 1'b1;
                res_node_sel = node_idx;
                out_data     = res_node_dout;
                if (last_node) begin
                    state_next = last_sample ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Batch configuration, loop counters, timeout counter and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            node_idx   <= '0;
            sample_idx <= '0;
            num_q      <= '0;
            eta_q      <= '0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            tmo_cnt    <= '0;
        end else if (accept) begin
            num_q      <= num_samples;
            eta_q      <= eta_cfg;
            err_q      <= 1'b0;
            sample_idx <= '0;
            node_idx   <= '0;
            addr_q     <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    node_idx <= last_node ? '0 : node_idx + NW'(1);
                end
                S_STEP: begin
                    tmo_cnt <= '0;
                end
                S_WAIT: begin
                    if (wait_go) begin
                        node_idx <= last_node ? '0 : node_idx + NW'(1);
                    end else if (wait_tmo) begin
                        err_q <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_READOUT: begin
                    addr_q   <= addr_q + ADDR_WIDTH'(1);
                    node_idx <= last_node ? '0 : node_idx + NW'(1);
                    if (last_node) begin
                        sample_idx <= sample_idx + ADDR_WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Masked input register: BRAM data is valid in LATCH, held through STEP and WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_q <= '0;
        end else if (state == S_LATCH) begin
            din_q <= scale_sat(smp_data, mask_data);
        end
    end

endmodule

// File: tb/tb_dfr_sequencer.sv
// tb_dfr_sequencer: randomized bench for dfr_sequencer with sample/mask BRAM
// models, a simple reservoir model and a batch-level reference model.
module tb_dfr_sequencer;

    localparam int N   = 4;
    localparam int NW  = 2;
    localparam int AW  = 16;
    localparam int TMO = 20;

    logic            clk;
    logic            rst;
    logic            start;
    logic [AW-1:0]   num_samples;
    logic [3:0]      eta_cfg;
    logic            busy;
    logic            done;
    logic            error;
    logic [AW-1:0]   smp_addr;
    logic [15:0]     smp_data;
    logic [NW-1:0]   mask_addr;
    logic [15:0]     mask_data;
    logic            res_en;
    logic [31:0]     res_din;
    logic [3:0]      res_eta;
    logic            res_valid;
    logic            res_load_node;
    logic [11:0]     res_load_din;
    logic [NW-1:0]   res_node_sel;
    logic [11:0]     res_node_dout;
    logic            out_we;
    logic [AW-1:0]   out_addr;
    logic [11:0]     out_data;

    dfr_sequencer #(
        .NUM_VIRTUAL_NODES(N),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .eta_cfg(eta_cfg), .busy(busy), .done(done), .error(error),
        .smp_addr(smp_addr), .smp_data(smp_data), .mask_addr(mask_addr),
        .mask_data(mask_data), .res_en(res_en), .res_din(res_din),
        .res_eta(res_eta), .res_valid(res_valid), .res_load_node(res_load_node),
        .res_load_din(res_load_din), .res_node_sel(res_node_sel),
        .res_node_dout(res_node_dout), .out_we(out_we), .out_addr(out_addr),
        .out_data(out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample and mask BRAMs, 1-cycle read latency.
    logic [15:0] smp_mem  [0:15];
    logic [15:0] mask_mem [0:N-1];
    always @(posedge clk) begin
        smp_data  <= smp_mem[smp_addr[3:0]];
        mask_data <= mask_mem[mask_addr];
    end

    // Reservoir model: each update adds masked input plus eta to the next
    // virtual node in rotation, then reports busy for a random few cycles.
    logic [11:0] rnode [0:N-1];
    int          rptr;
    int          rbusy;
    logic        rhang;
    logic        hang_mode;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr  <= 0;
            rbusy <= 0;
            rhang <= 1'b0;
        end else if (res_load_node) begin
            rnode[res_node_sel] <= res_load_din;
            rptr  <= 0;
            rbusy <= 0;
            rhang <= 1'b0;
        end else if (res_en) begin
            rnode[rptr] <= rnode[rptr] + res_din[11:0] + {8'h00, res_eta};
            rptr  <= (rptr == N - 1) ? 0 : rptr + 1;
            rbusy <= int'($urandom_range(0, 4));
            if (hang_mode) rhang <= 1'b1;
        end else if (rbusy > 0) begin
            rbusy <= rbusy - 1;
        end
    end
    assign res_valid     = !rhang && (rbusy == 0);
    assign res_node_dout = rnode[res_node_sel];

    // Event monitor, sampled on the inactive edge.
    logic [31:0]   en_din_q  [$];
    logic [3:0]    en_eta_q  [$];
    logic [NW-1:0] ld_sel_q  [$];
    logic [AW-1:0] we_addr_q [$];
    logic [11:0]   we_data_q [$];
    int            done_cnt  = 0;
    int            excl_bad  = 0;
    always @(negedge clk) begin
        if (res_en) begin
            en_din_q.push_back(res_din);
            en_eta_q.push_back(res_eta);
        end
        if (res_load_node) ld_sel_q.push_back(res_node_sel);
        if (out_we) begin
            we_addr_q.push_back(out_addr);
            we_data_q.push_back(out_data);
        end
        if (done) done_cnt++;
        if (int'(res_en) + int'(res_load_node) + int'(out_we) > 1) excl_bad++;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference masked input: floor(sample*mask / 256), clamped to 0xFFFF.
    function automatic logic [31:0] model_din(input int unsigned s, input int unsigned m);
        longint p;
        p = (longint'(s) * longint'(m)) / 256;
        if (p > 65535) p = 65535;
        return 32'(p);
    endfunction

    task automatic fill_rand();
        for (int i = 0; i < 16; i++) smp_mem[i] = 16'($urandom);
        for (int i = 0; i < N; i++) mask_mem[i] = 16'($urandom);
    endtask

    // Runs one batch and compares every observed transaction against the model.
    task automatic run_batch(input int ns, input logic [3:0] eta, input bit hang,
                             input bit spam, output int eb);
        int          lb, wb, db, idx;
        bit          seen;
        logic [11:0] node [N];
        logic [31:0] d;
        eb = en_din_q.size();
        lb = ld_sel_q.size();
        wb = we_addr_q.size();
        db = done_cnt;
        hang_mode = hang;
        @(posedge clk); #1;
        num_samples = AW'(ns);
        eta_cfg     = eta;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (spam) begin
            eta_cfg     = ~eta;
            num_samples = AW'(7);
        end
        @(negedge clk);
        if (ns == 0) begin
            chk("zero_done_next_cycle", done, 1);
        end else begin
            chk("busy_after_start", busy, 1);
            chk("error_cleared_on_start", error, 0);
        end
        seen = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (done_cnt > db) begin
                seen = 1;
                break;
            end
            if (spam) start = (cyc % 9 == 4);
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_seen", seen, 1);
        repeat (3) @(negedge clk);
        chk("done_single_pulse", done_cnt - db, 1);
        chk("busy_low_after_done", busy, 0);
        chk("error_flag", error, hang);
        if (ns == 0) begin
            chk("zero_res_en", en_din_q.size() - eb, 0);
            chk("zero_loads", ld_sel_q.size() - lb, 0);
            chk("zero_writes", we_addr_q.size() - wb, 0);
        end else if (hang) begin
            chk("tmo_loads", ld_sel_q.size() - lb, N);
            chk("tmo_res_en", en_din_q.size() - eb, 1);
            chk("tmo_no_writes", we_addr_q.size() - wb, 0);
        end else begin
            chk("clear_count", ld_sel_q.size() - lb, N);
            if (ld_sel_q.size() - lb == N)
                for (int k = 0; k < N; k++) chk("clear_sel", ld_sel_q[lb + k], k);
            chk("res_en_count", en_din_q.size() - eb, ns * N);
            chk("write_count", we_addr_q.size() - wb, ns * N);
            if ((en_din_q.size() - eb == ns * N) && (we_addr_q.size() - wb == ns * N)) begin
                for (int k = 0; k < N; k++) node[k] = 12'h000;
                idx = 0;
                for (int s = 0; s < ns; s++) begin
                    for (int k = 0; k < N; k++) begin
                        d = model_din(smp_mem[s], mask_mem[k]);
                        chk("res_din", en_din_q[eb + s * N + k], d);
                        chk("res_eta", en_eta_q[eb + s * N + k], eta);
                        node[k] = node[k] + d[11:0] + {8'h00, eta};
                    end
                    for (int k = 0; k < N; k++) begin
                        chk("out_addr", we_addr_q[wb + idx], idx);
                        chk("out_data", we_data_q[wb + idx], node[k]);
                        idx++;
                    end
                end
            end
        end
    endtask

    // Resets the design while it is writing node states out.
    task automatic reset_mid_readout();
        bit found;
        int wc;
        fill_rand();
        hang_mode = 1'b0;
        @(posedge clk); #1;
        num_samples = AW'(2);
        eta_cfg     = 4'h5;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (out_we) begin
                found = 1;
                break;
            end
        end
        chk("reached_readout", found, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_out_we_low", out_we, 0);
        chk("rst_busy_low", busy, 0);
        chk("rst_error_low", error, 0);
        chk("rst_res_en_low", res_en, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        wc = we_addr_q.size();
        repeat (6) @(negedge clk);
        chk("no_write_after_rst", we_addr_q.size() - wc, 0);
        chk("idle_after_rst", busy, 0);
    endtask

    int eb;

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        num_samples = '0;
        eta_cfg     = '0;
        hang_mode   = 1'b0;
        fill_rand();
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_error", error, 0);
        chk("reset_strobes", {res_en, res_load_node, out_we}, 0);
        chk("reset_res_din", res_din, 0);
        chk("reset_addrs", {smp_addr, out_addr, mask_addr, res_node_sel}, 0);
        chk("reset_eta", res_eta, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Unity scaling: 0x0100 * 0x0100 >> 8 = 0x0100 on every node.
        smp_mem[0] = 16'h0100;
        for (int i = 0; i < N; i++) mask_mem[i] = 16'h0100;
        run_batch(1, 4'h3, 1'b0, 1'b0, eb);
        if (en_din_q.size() > eb) chk("unity_din", en_din_q[eb], 32'h0000_0100);

        // Saturation and small-value truncation.
        smp_mem[0] = 16'hFFFF;
        smp_mem[1] = 16'h0002;
        mask_mem[0] = 16'hFFFF;
        mask_mem[1] = 16'h0080;
        mask_mem[2] = 16'hFFFF;
        mask_mem[3] = 16'h0080;
        run_batch(2, 4'h1, 1'b0, 1'b0, eb);
        if (en_din_q.size() > eb + 5) begin
            chk("sat_din", en_din_q[eb], 32'h0000_FFFF);
            chk("small_din", en_din_q[eb + 5], 32'h0000_0001);
        end

        run_batch(0, 4'h2, 1'b0, 1'b0, eb);

        fill_rand();
        run_batch(3, 4'hA, 1'b0, 1'b1, eb);

        fill_rand();
        run_batch(1, 4'h6, 1'b1, 1'b0, eb);
        fill_rand();
        run_batch(2, 4'h4, 1'b0, 1'b0, eb);

        reset_mid_readout();
        fill_rand();
        run_batch(2, 4'h9, 1'b0, 1'b0, eb);

        for (int r = 0; r < 3; r++) begin
            fill_rand();
            run_batch(int'($urandom_range(1, 4)), 4'($urandom), 1'b0, 1'(r == 1), eb);
        end

        chk("strobe_exclusive", excl_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
